// File: rtl/db_bs_gen_pkg.sv
// Shared constants for the deblocking boundary-strength generator:
// MV RAM address bases, MV threshold, BS encodings, block count.
package db_bs_gen_pkg;

  localparam int FMV_WIDTH_DEF = 10;

  localparam int ADDR_TOP_BASE  = 64;
  localparam int ADDR_LEFT_BASE = 72;
  localparam int MV_THR_DEF     = 4;
  localparam int BLK_CNT        = 64;
  localparam logic [5:0] BLK_LAST = 6'(BLK_CNT - 1);

  typedef logic [1:0] bs_t;

  localparam bs_t BS_NONE  = 2'd0;
  localparam bs_t BS_WEAK  = 2'd1;
  localparam bs_t BS_INTRA = 2'd2;

  // Picture-boundary edges are never filtered; intra overrides the MV result.
  function automatic bs_t edge_bs(input logic no_filter, input logic intra,
                                  input logic mv_hit);
    if (no_filter)  return BS_NONE;
    else if (intra) return BS_INTRA;
    else if (mv_hit) return BS_WEAK;
    else            return BS_NONE;
  endfunction

endpackage

// File: rtl/db_bs_mv_cmp.sv
// Combinational MV compare: BS=1 when either component differs by at least
// MV_THR quarter-pels. Differences are formed one bit wider than a component
// so the full signed range cannot overflow.
module db_bs_mv_cmp #(
  parameter int FMV_WIDTH = 10,
  parameter int MV_THR    = 4
) (
  input  logic [2*FMV_WIDTH-1:0] mv_a_i,
  input  logic [2*FMV_WIDTH-1:0] mv_b_i,
  output logic                   bs_o
);

  localparam logic [FMV_WIDTH:0] THR = (FMV_WIDTH+1)'(MV_THR);
  localparam logic [FMV_WIDTH:0] ONE = (FMV_WIDTH+1)'(1);

  logic [FMV_WIDTH-1:0] ax, ay, bx, by;
  logic [FMV_WIDTH:0]   dx, dy, adx, ady;

  // Sign-extended component differences, their magnitudes and the threshold test
  always_comb begin
    ax  = mv_a_i[FMV_WIDTH-1:0];
    ay  = mv_a_i[2*FMV_WIDTH-1:FMV_WIDTH];
    bx  = mv_b_i[FMV_WIDTH-1:0];
    by  = mv_b_i[2*FMV_WIDTH-1:FMV_WIDTH];
    dx  = {ax[FMV_WIDTH-1], ax} - {bx[FMV_WIDTH-1], bx};
    dy  = {ay[FMV_WIDTH-1], ay} - {by[FMV_WIDTH-1], by};
    adx = dx[FMV_WIDTH] ? (~dx + ONE) : dx;
    ady = dy[FMV_WIDTH] ? (~dy + ONE) : dy;
    bs_o = (adx >= THR) || (ady >= THR);
  end

endmodule

// File: rtl/db_bs_gen.sv
// Boundary-strength generator. Walks the 64 8x8 blocks of one 64x64 LCU in
// raster order, reading current, left and top MVs from the MV RAM B port,
// and emits one vertical-edge and one horizontal-edge BS per block.
// Optional macro DB_BS_INTRA_EN adds intra_i: when latched high every
// non-picture-boundary edge gets BS=2.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for start_i
// RD_CUR  | address the current block's MV
// RD_LEFT | address left neighbour, capture current MV
// RD_TOP  | address top neighbour, capture left MV
// WAIT    | last block's top MV arrives, BS of block 63 computed
module db_bs_gen
  import db_bs_gen_pkg::*;
#(
  parameter int FMV_WIDTH  = FMV_WIDTH_DEF,
  parameter int ADDR_WIDTH = 7,
  parameter int MV_THR     = MV_THR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef DB_BS_INTRA_EN
  input  logic                   intra_i,
`endif
  input  logic                   start_i,
  input  logic                   pic_left_i,
  input  logic                   pic_top_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cen_o,
  output logic                   ren_o,
  output logic                   wen_o,
  output logic [ADDR_WIDTH-1:0]  addr_o,
  input  logic [2*FMV_WIDTH-1:0] mv_i,
  output logic                   bs_valid_o,
  output logic [5:0]             bs_idx_o,
  output logic [1:0]             bs_v_o,
  output logic [1:0]             bs_h_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_CUR  = 3'd1;
  localparam logic [2:0] ST_RD_LEFT = 3'd2;
  localparam logic [2:0] ST_RD_TOP  = 3'd3;
  localparam logic [2:0] ST_WAIT    = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [5:0]             blk_q, blk_d;
  logic                   pic_left_q, pic_left_d;
  logic                   pic_top_q, pic_top_d;
  logic [2*FMV_WIDTH-1:0] cur_q, cur_d;
  logic [2*FMV_WIDTH-1:0] left_q, left_d;
  logic                   pend_q, pend_d;
  logic [5:0]             pend_idx_q, pend_idx_d;
  logic                   bs_valid_q, bs_valid_d;
  logic                   done_q, done_d;
  logic [5:0]             bs_idx_q, bs_idx_d;
  bs_t                    bs_v_q, bs_v_d;
  bs_t                    bs_h_q, bs_h_d;
  logic                   intra_en;
`ifdef DB_BS_INTRA_EN
  logic                   intra_q, intra_d;
  assign intra_en = intra_q;
`else
  assign intra_en = 1'b0;
`endif

  logic cmp_left, cmp_top;
  logic [2:0] blk_x, blk_y, pend_x, pend_y;

  assign blk_x  = blk_q[2:0];
  assign blk_y  = blk_q[5:3];
  assign pend_x = pend_idx_q[2:0];
  assign pend_y = pend_idx_q[5:3];

  // Left edge: captured current MV vs captured left MV
  db_bs_mv_cmp #(.FMV_WIDTH(FMV_WIDTH), .MV_THR(MV_THR)) u_cmp_left (
    .mv_a_i (cur_q),
    .mv_b_i (left_q),
    .bs_o   (cmp_left)
  );

  // Top edge: top MV is used straight off the RAM data bus
  db_bs_mv_cmp #(.FMV_WIDTH(FMV_WIDTH), .MV_THR(MV_THR)) u_cmp_top (
    .mv_a_i (cur_q),
    .mv_b_i (mv_i),
    .bs_o   (cmp_top)
  );

  // Sequencer: state, block counter, boundary latches and MV capture
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    pic_left_d = pic_left_q;
    pic_top_d  = pic_top_q;
    cur_d      = cur_q;
    left_d     = left_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
`ifdef DB_BS_INTRA_EN
    intra_d    = intra_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_RD_CUR;
          blk_d      = 6'd0;
          pic_left_d = pic_left_i;
          pic_top_d  = pic_top_i;
`ifdef DB_BS_INTRA_EN
          intra_d    = intra_i;
`endif
        end
      end
      ST_RD_CUR:  state_d = ST_RD_LEFT;
      ST_RD_LEFT: begin
        cur_d   = mv_i;
        state_d = ST_RD_TOP;
      end
      ST_RD_TOP: begin
        left_d     = mv_i;
        pend_d     = 1'b1;
        pend_idx_d = blk_q;
        if (blk_q == BLK_LAST) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RD_CUR;
          blk_d   = blk_q + 6'd1;
        end
      end
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // BS results for the block whose top MV is on the bus this cycle
  always_comb begin
    bs_valid_d = pend_q;
    done_d     = pend_q && (pend_idx_q == BLK_LAST);
    bs_idx_d   = bs_idx_q;
    bs_v_d     = bs_v_q;
    bs_h_d     = bs_h_q;
    if (pend_q) begin
      bs_idx_d = pend_idx_q;
      bs_v_d   = edge_bs(pic_left_q && (pend_x == 3'd0), intra_en, cmp_left);
      bs_h_d   = edge_bs(pic_top_q && (pend_y == 3'd0), intra_en, cmp_top);
    end
  end

  // RAM address per read state; zero outside reads
  always_comb begin
    addr_o = '0;
    case (state_q)
      ST_RD_CUR:  addr_o = ADDR_WIDTH'(blk_q);
      ST_RD_LEFT: addr_o = (blk_x != 3'd0) ? ADDR_WIDTH'(blk_q - 6'd1)
                         : ADDR_WIDTH'(ADDR_LEFT_BASE) + ADDR_WIDTH'(blk_y);
      ST_RD_TOP:  addr_o = (blk_y != 3'd0) ? ADDR_WIDTH'(blk_q - 6'd8)
                         : ADDR_WIDTH'(ADDR_TOP_BASE) + ADDR_WIDTH'(blk_x);
      default:    addr_o = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      blk_q      <= '0;
      pic_left_q <= 1'b0;
      pic_top_q  <= 1'b0;
      cur_q      <= '0;
      left_q     <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      bs_valid_q <= 1'b0;
      done_q     <= 1'b0;
      bs_idx_q   <= '0;
      bs_v_q     <= BS_NONE;
      bs_h_q     <= BS_NONE;
`ifdef DB_BS_INTRA_EN
      intra_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      pic_left_q <= pic_left_d;
      pic_top_q  <= pic_top_d;
      cur_q      <= cur_d;
      left_q     <= left_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      bs_valid_q <= bs_valid_d;
      done_q     <= done_d;
      bs_idx_q   <= bs_idx_d;
      bs_v_q     <= bs_v_d;
      bs_h_q     <= bs_h_d;
`ifdef DB_BS_INTRA_EN
      intra_q    <= intra_d;
`endif
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign cen_o      = !((state_q == ST_RD_CUR) || (state_q == ST_RD_LEFT) ||
                        (state_q == ST_RD_TOP));
  assign ren_o      = !busy_o;
  assign wen_o      = 1'b1;
  assign done_o     = done_q;
  assign bs_valid_o = bs_valid_q;
  assign bs_idx_o   = bs_idx_q;
  assign bs_v_o     = bs_v_q;
  assign bs_h_o     = bs_h_q;

endmodule

// File: tb/tb_db_bs_gen.sv
// Directed bench for db_bs_gen with a behavioural 80-entry MV RAM
// (one-cycle read latency). Build with +define+DB_BS_INTRA_EN to add the
// intra run.
module tb_db_bs_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        pic_left_i = 1'b0;
  logic        pic_top_i = 1'b0;
`ifdef DB_BS_INTRA_EN
  logic        intra_i = 1'b0;
`endif
  logic        busy_o, done_o, cen_o, ren_o, wen_o, bs_valid_o;
  logic [6:0]  addr_o;
  logic [19:0] mv_i;
  logic [5:0]  bs_idx_o;
  logic [1:0]  bs_v_o, bs_h_o;

  logic [19:0] mem [0:79];
  logic [19:0] rdata = '0;

  int errors = 0;
  int checks = 0;
  int exp_v [0:63];
  int exp_h [0:63];

  always #5 clk = ~clk;

  always @(posedge clk) if (!cen_o && !ren_o) rdata <= mem[addr_o];
  assign mv_i = rdata;

  db_bs_gen dut (
    .clk        (clk),
    .rst        (rst),
`ifdef DB_BS_INTRA_EN
    .intra_i    (intra_i),
`endif
    .start_i    (start_i),
    .pic_left_i (pic_left_i),
    .pic_top_i  (pic_top_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .cen_o      (cen_o),
    .ren_o      (ren_o),
    .wen_o      (wen_o),
    .addr_o     (addr_o),
    .mv_i       (mv_i),
    .bs_valid_o (bs_valid_o),
    .bs_idx_o   (bs_idx_o),
    .bs_v_o     (bs_v_o),
    .bs_h_o     (bs_h_o)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 80; i++) mem[i] = 20'h0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) begin
      exp_v[i] = 0;
      exp_h[i] = 0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":busy"},  busy_o, 0);
    chk({tag, ":done"},  done_o, 0);
    chk({tag, ":cen"},   cen_o, 1);
    chk({tag, ":ren"},   ren_o, 1);
    chk({tag, ":wen"},   wen_o, 1);
    chk({tag, ":addr"},  addr_o, 0);
    chk({tag, ":valid"}, bs_valid_o, 0);
    chk({tag, ":idx"},   bs_idx_o, 0);
    chk({tag, ":bs_v"},  bs_v_o, 0);
    chk({tag, ":bs_h"},  bs_h_o, 0);
  endtask

  // One LCU. k counts cycles after the start-sampling edge t; samples at negedge.
  // pic inputs are dropped right after start to confirm they were latched.
  task automatic run_lcu(input string tag, input logic pl, input logic pt,
                         input int rst_at, input int busy_start_at);
    bit killed = 0;
    int n, ph, x, y, ea;
    @(negedge clk);
    start_i = 1'b1;
    pic_left_i = pl;
    pic_top_i = pt;
    @(posedge clk);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start_i = (k == busy_start_at);
      pic_left_i = 1'b0;
      pic_top_i = 1'b0;
      if (killed) rst = 1'b0;
      if (rst_at != 0 && k == rst_at) begin
        rst = 1'b1;
        #1;
        chk_reset_outputs({tag, ":midrst"});
        killed = 1;
      end else if (killed) begin
        chk({tag, ":post_rst_busy"},  busy_o, 0);
        chk({tag, ":post_rst_valid"}, bs_valid_o, 0);
        chk({tag, ":post_rst_done"},  done_o, 0);
      end else begin
        chk({tag, ":busy"}, busy_o, int'(k <= 193));
        chk({tag, ":ren"},  ren_o, int'(k > 193));
        chk({tag, ":done"}, done_o, int'(k == 194));
        chk({tag, ":wen"},  wen_o, 1);
        if (k <= 192) begin
          n = (k - 1) / 3;
          ph = (k - 1) % 3;
          x = n % 8;
          y = n / 8;
          if (ph == 0)      ea = n;
          else if (ph == 1) ea = (x > 0) ? n - 1 : 72 + y;
          else              ea = (y > 0) ? n - 8 : 64 + x;
          chk({tag, ":cen"},  cen_o, 0);
          chk({tag, ":addr"}, addr_o, ea);
        end else begin
          chk({tag, ":cen_off"}, cen_o, 1);
        end
        if (k >= 5 && k <= 194 && ((k - 5) % 3 == 0)) begin
          n = (k - 5) / 3;
          chk({tag, ":valid"}, bs_valid_o, 1);
          chk({tag, ":idx"},   bs_idx_o, n);
          chk({tag, $sformatf(":bs_v[%0d]", n)}, bs_v_o, exp_v[n]);
          chk({tag, $sformatf(":bs_h[%0d]", n)}, bs_h_o, exp_h[n]);
        end else begin
          chk({tag, ":valid_off"}, bs_valid_o, 0);
        end
      end
    end
    start_i = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    clear_mem();
    clear_exp();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("idle");

    // All zero: no edges
    run_lcu("zero", 1'b0, 1'b0, 0, 0);

    // Single moved block at entry 9 (x=1,y=1), with a stray start mid-run
    clear_mem();
    mem[9] = {10'd0, 10'd4};
    clear_exp();
    exp_v[9] = 1; exp_h[9] = 1; exp_v[10] = 1; exp_h[17] = 1;
    run_lcu("blk9", 1'b0, 1'b0, 0, 30);

    // Left neighbour of block 0 just under, then at, the threshold
    clear_mem();
    mem[72] = {10'h3FD, 10'h000};
    clear_exp();
    run_lcu("left_m3", 1'b0, 1'b0, 0, 0);
    mem[72] = {10'h3FC, 10'h000};
    exp_v[0] = 1;
    run_lcu("left_m4", 1'b0, 1'b0, 0, 0);

    // Large neighbours at picture edges: boundary edges suppressed
    clear_mem();
    for (int i = 64; i < 80; i++) mem[i] = 20'h7FFFF;
    clear_exp();
    run_lcu("pic_edge", 1'b1, 1'b1, 0, 0);

    // Same neighbours away from picture edges: boundary edges filtered
    for (int i = 0; i < 8; i++) begin
      exp_v[i * 8] = 1;
      exp_h[i] = 1;
    end
    run_lcu("inner_edge", 1'b0, 1'b0, 0, 0);

    // Reset mid-LCU, then a full normal run
    clear_mem();
    clear_exp();
    run_lcu("midrst", 1'b0, 1'b0, 50, 0);
    run_lcu("after_rst", 1'b0, 1'b0, 0, 0);

`ifdef DB_BS_INTRA_EN
    clear_mem();
    for (int i = 0; i < 64; i++) begin
      exp_v[i] = 2;
      exp_h[i] = (i < 8) ? 0 : 2;
    end
    intra_i = 1'b1;
    run_lcu("intra", 1'b0, 1'b1, 0, 0);
    intra_i = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
